// File: rtl/dpram_be_pipe_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package dpram_be_pipe_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dpram_be_pipe_if.sv
// Request/response bundle for dpram_be_pipe: write port A, read port B, init status.
interface dpram_be_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
);
    // Requests are single-cycle pulses with no back-pressure: wen/ren are taken at
    // the clock edge unless init_busy is high; doutb_valid is a one-cycle strobe
    // qualifying doutb, one per accepted read, with no ready to stall it.
    logic                 wen;
    logic [WIDTH/8-1:0]   wbe;
    logic [AW-1:0]        addra;
    logic [WIDTH-1:0]     dina;
    logic                 ren;
    logic [AW-1:0]        addrb;
    logic [WIDTH-1:0]     doutb;
    logic                 doutb_valid;
    logic                 init_busy;

    modport master (
        output wen, wbe, addra, dina, ren, addrb,
        input  doutb, doutb_valid, init_busy
    );

    modport slave (
        input  wen, wbe, addra, dina, ren, addrb,
        output doutb, doutb_valid, init_busy
    );
endinterface

// File: rtl/dpram_be_pipe_init_ctrl.sv
// Post-reset zero-clear sweep: walks every word once and holds init_busy meanwhile.
module dpram_be_pipe_init_ctrl
    import dpram_be_pipe_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int AW             = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          init_busy_o,
    output clr_state_e    state_o
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
            else                state_q <= ST_IDLE;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // rst masks the clear write so reset alone never touches the array.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_o = ~rst;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign clr_addr_o  = cnt_q;
    assign init_busy_o = (state_q == ST_CLEAR);
    assign state_o     = state_q;

endmodule

// File: rtl/dpram_be_pipe.sv
// Simple dual-port RAM with byte-lane writes, write->read bypass and 1/2-cycle read pipe.
module dpram_be_pipe
    import dpram_be_pipe_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    dpram_be_pipe_if.slave bus,
    output clr_state_e     dbg_state_o
);
    localparam int          AW      = clog2_min1(DEPTH);
    localparam int          NBYTES  = WIDTH / 8;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("dpram_be_pipe: WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_lat
        $error("dpram_be_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("dpram_be_pipe: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          init_busy;

    dpram_be_pipe_init_ctrl #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init (
        .clk         (clk),
        .rst         (rst),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .init_busy_o (init_busy),
        .state_o     (dbg_state_o)
    );

    logic wr_acc, rd_acc, rd_in_range, collide;

    assign wr_acc      = bus.wen & ~init_busy & ~rst & ({1'b0, bus.addra} < DEPTH_W);
    assign rd_acc      = bus.ren & ~init_busy & ~rst;
    assign rd_in_range = ({1'b0, bus.addrb} < DEPTH_W);
    assign collide     = BYPASS && wr_acc && (bus.addra == bus.addrb);

    // Port A is shared between the clear sweep and user writes; they never overlap.
    logic              pa_we;
    logic [AW-1:0]     pa_addr;
    logic [WIDTH-1:0]  pa_data;
    logic [NBYTES-1:0] pa_be;

    always_comb begin
        pa_we   = wr_acc;
        pa_addr = bus.addra;
        pa_data = bus.dina;
        pa_be   = bus.wbe;
        if (clr_we) begin
            pa_we   = 1'b1;
            pa_addr = clr_addr;
            pa_data = '0;
            pa_be   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (pa_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (pa_be[i]) mem[pa_addr][8*i +: 8] <= pa_data[8*i +: 8];
            end
        end
    end

    logic [WIDTH-1:0] rd_old, rd_merged;

    always_comb begin
        rd_old    = rd_in_range ? mem[bus.addrb] : '0;
        rd_merged = rd_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (collide && bus.wbe[i]) rd_merged[8*i +: 8] = bus.dina[8*i +: 8];
        end
    end

    // Stage 0 is the RAM read register; READ_LATENCY output stages follow it.
    // Stages only load on valid so doutb holds between reads.
    logic [READ_LATENCY:0] vld_q;
    logic [WIDTH-1:0]      dat_q [READ_LATENCY+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) dat_q[0] <= rd_merged;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign bus.doutb       = dat_q[READ_LATENCY];
    assign bus.doutb_valid = vld_q[READ_LATENCY];
    assign bus.init_busy   = init_busy;

endmodule

// File: tb/tb_dpram_be_pipe.sv
// Two instances (1024/LAT1/bypass and 1000/LAT2/no-bypass) fed identical stimulus, checked against a word-level model.
module tb_dpram_be_pipe;
    import dpram_be_pipe_pkg::*;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int NB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wen = 1'b0, ren = 1'b0;
    logic [NB-1:0] wbe = '0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [W-1:0]  dina = '0;

    dpram_be_pipe_if #(.WIDTH(W), .AW(AW)) bus_a ();
    dpram_be_pipe_if #(.WIDTH(W), .AW(AW)) bus_b ();
    clr_state_e dbg_a, dbg_b;

    assign bus_a.wen = wen;  assign bus_a.wbe = wbe;  assign bus_a.addra = addra;
    assign bus_a.dina = dina; assign bus_a.ren = ren; assign bus_a.addrb = addrb;
    assign bus_b.wen = wen;  assign bus_b.wbe = wbe;  assign bus_b.addra = addra;
    assign bus_b.dina = dina; assign bus_b.ren = ren; assign bus_b.addrb = addrb;

    dpram_be_pipe #(.WIDTH(W), .DEPTH(1024), .READ_LATENCY(1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a), .dbg_state_o(dbg_a));
    dpram_be_pipe #(.WIDTH(W), .DEPTH(1000), .READ_LATENCY(2), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b), .dbg_state_o(dbg_b));

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int           k;
        int           due;
        logic [W-1:0] data;
    } exp_t;

    int           p_depth [2] = '{1024, 1000};
    int           p_lat   [2] = '{1, 2};
    bit           p_byp   [2] = '{1'b1, 1'b0};
    logic [W-1:0] mmem    [2][1024];
    int           busy_left [2] = '{0, 0};
    bit           started   [2] = '{1'b0, 1'b0};
    bit           exp_valid [2] = '{1'b0, 1'b0};
    logic [W-1:0] exp_dout  [2];
    exp_t         exp_q[$];
    int           cyc = 0;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                           input logic [NB-1:0] be);
        logic [W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic model_step(input int k);
        bit busy, wr, rd;
        logic [W-1:0] v;
        exp_t e;
        if (rst) begin
            started[k]   = 1'b1;
            busy_left[k] = p_depth[k];
            for (int i = 0; i < 1024; i++) mmem[k][i] = '0;
            for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].k == k) exp_q.delete(i);
            exp_valid[k] = 1'b0;
            exp_dout[k]  = '0;
        end else if (started[k]) begin
            busy = busy_left[k] > 0;
            wr   = wen && !busy && (int'(addra) < p_depth[k]);
            rd   = ren && !busy;
            if (rd) begin
                if (int'(addrb) >= p_depth[k]) v = '0;
                else begin
                    v = mmem[k][addrb];
                    if (p_byp[k] && wr && addra == addrb) v = merge(v, dina, wbe);
                end
                e.k = k; e.due = cyc + p_lat[k]; e.data = v;
                exp_q.push_back(e);
            end
            if (wr) mmem[k][addra] = merge(mmem[k][addra], dina, wbe);
            if (busy) busy_left[k]--;
            exp_valid[k] = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].k == k && exp_q[i].due == cyc) begin
                    exp_valid[k] = 1'b1;
                    exp_dout[k]  = exp_q[i].data;
                    exp_q.delete(i);
                    break;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    // Outputs are all registered, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (started[0]) begin
            check($sformatf("a_busy@%0d", cyc), 32'(bus_a.init_busy), 32'(busy_left[0] > 0));
            check($sformatf("a_state@%0d", cyc), 32'(dbg_a), 32'((busy_left[0] > 0) ? ST_CLEAR : ST_IDLE));
            check($sformatf("a_valid@%0d", cyc), 32'(bus_a.doutb_valid), 32'(exp_valid[0]));
            check($sformatf("a_dout@%0d", cyc), bus_a.doutb, exp_dout[0]);
        end
        if (started[1]) begin
            check($sformatf("b_busy@%0d", cyc), 32'(bus_b.init_busy), 32'(busy_left[1] > 0));
            check($sformatf("b_state@%0d", cyc), 32'(dbg_b), 32'((busy_left[1] > 0) ? ST_CLEAR : ST_IDLE));
            check($sformatf("b_valid@%0d", cyc), 32'(bus_b.doutb_valid), 32'(exp_valid[1]));
            check($sformatf("b_dout@%0d", cyc), bus_b.doutb, exp_dout[1]);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) < 7) return AW'($urandom_range(0, 15));
        return AW'($urandom_range(990, 1023));
    endfunction

    task automatic idle();
        wen = 1'b0; ren = 1'b0; wbe = '0;
    endtask

    task automatic rand_req();
        wen   = 1'($urandom_range(0, 1));
        ren   = 1'($urandom_range(0, 1));
        wbe   = NB'($urandom_range(0, 15));
        addra = rand_addr();
        addrb = rand_addr();
        dina  = $urandom();
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [NB-1:0] be);
        wen = 1'b1; addra = AW'(a); dina = d; wbe = be;
        @(negedge clk);
        idle();
    endtask

    // Optional same-cycle write, one read; returns first data per instance and edges after acceptance.
    task automatic access(input bit do_w, input int wa, input logic [W-1:0] wd, input logic [NB-1:0] be,
                          input int ra, output logic [W-1:0] da, output logic [W-1:0] db,
                          output int la, output int lb);
        bit fa, fb;
        fa = 1'b0; fb = 1'b0; la = -1; lb = -1; da = 'x; db = 'x;
        wen = do_w; addra = AW'(wa); dina = wd; wbe = be;
        ren = 1'b1; addrb = AW'(ra);
        for (int n = 1; n <= 8 && !(fa && fb); n++) begin
            @(negedge clk);
            if (n == 1) idle();
            if (bus_a.doutb_valid && !fa) begin fa = 1'b1; la = n - 1; da = bus_a.doutb; end
            if (bus_b.doutb_valid && !fb) begin fb = 1'b1; lb = n - 1; db = bus_b.doutb; end
        end
    endtask

    // Call at the falling edge where rst drops; random requests while both are clearing.
    task automatic sweep_check(input string tag);
        int na, nb, n;
        na = 0; nb = 0; n = 0;
        while ((na == 0 || nb == 0) && n < 3000) begin
            if (bus_a.init_busy && bus_b.init_busy) rand_req(); else idle();
            @(negedge clk);
            n++;
            if (!bus_a.init_busy && na == 0) na = n;
            if (!bus_b.init_busy && nb == 0) nb = n;
        end
        idle();
        check({tag, "_len_a"}, 32'(na), 32'd1024);
        check({tag, "_len_b"}, 32'(nb), 32'd1000);
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] da, db;
    int           la, lb;
    logic [W-1:0] qa[$], qb[$];

    initial begin
        int fa, ka, fb, kb, va, vb;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sweep_check("sweep0");

        access(1'b0, 0, '0, '0, 'h3FF, da, db, la, lb);
        check("rd3ff_a", da, 32'h0);
        check("rd3ff_b", db, 32'h0);

        wr(5, 32'hDEADBEEF, 4'hF);
        wr(5, 32'h000000AA, 4'h1);
        access(1'b0, 0, '0, '0, 5, da, db, la, lb);
        check("rd5_a", da, 32'hDEADBEAA);
        check("rd5_b", db, 32'hDEADBEAA);
        check("lat_a", 32'(la), 32'd1);
        check("lat_b", 32'(lb), 32'd2);

        wr(7, 32'h11223344, 4'hF);
        access(1'b1, 7, 32'hAABBCCDD, 4'hC, 7, da, db, la, lb);
        check("coll_a", da, 32'hAABB3344);
        check("coll_b", db, 32'h11223344);
        access(1'b0, 0, '0, '0, 7, da, db, la, lb);
        check("after_coll_a", da, 32'hAABB3344);
        check("after_coll_b", db, 32'hAABB3344);

        for (int i = 0; i < 16; i++) wr(i, W'(i * 3), 4'hF);
        fa = -1; ka = -1; fb = -1; kb = -1;
        for (int n = 0; n < 22; n++) begin
            if (n < 16) begin ren = 1'b1; addrb = AW'(n); end else ren = 1'b0;
            @(negedge clk);
            if (bus_a.doutb_valid) begin if (fa < 0) fa = n; ka = n; qa.push_back(bus_a.doutb); end
            if (bus_b.doutb_valid) begin if (fb < 0) fb = n; kb = n; qb.push_back(bus_b.doutb); end
        end
        check("burst_cnt_a", 32'(qa.size()), 32'd16);
        check("burst_cnt_b", 32'(qb.size()), 32'd16);
        check("burst_span_a", 32'(ka - fa), 32'd15);
        check("burst_span_b", 32'(kb - fb), 32'd15);
        for (int i = 0; i < qa.size(); i++) check($sformatf("burst_a[%0d]", i), qa[i], W'(i * 3));
        for (int i = 0; i < qb.size(); i++) check($sformatf("burst_b[%0d]", i), qb[i], W'(i * 3));

        wr(1010, 32'h12345678, 4'hF);
        access(1'b0, 0, '0, '0, 1010, da, db, la, lb);
        check("rd1010_a", da, 32'h12345678);
        check("rd1010_b", db, 32'h0);
        check("rd1010_b_lat", 32'(lb), 32'd2);

        for (int n = 0; n < 3000; n++) begin
            rand_req();
            @(negedge clk);
        end
        idle();

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 500; n++) begin
            rand_req();
            @(negedge clk);
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sweep_check("resweep");
        access(1'b0, 0, '0, '0, 5, da, db, la, lb);
        check("rd5_cleared_a", da, 32'h0);
        check("rd5_cleared_b", db, 32'h0);

        repeat (5) @(negedge clk);
        va = 0; vb = 0;
        ren = 1'b1; addrb = AW'(3);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) addrb = AW'(4);
            if (n == 2) begin ren = 1'b0; rst = 1'b1; end
            if (n == 3) rst = 1'b0;
            if (bus_a.doutb_valid) va++;
            if (bus_b.doutb_valid) vb++;
        end
        check("inflight_valid_a", 32'(va), 32'd1);
        check("inflight_valid_b", 32'(vb), 32'd0);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
